// File: rtl/mul_64b.sv
// Iterative signed 64x64->128 radix-4 Booth multiplier: one digit per clock, 32 busy cycles, init_i ignored while busy.
// Define MUL_64B_EARLY_EXIT_EN to complete as soon as every remaining Booth digit would be zero.
module mul_64b (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          init_i,
   output logic          done_o,
   input  logic [63:0]   multiplicand_i,
   input  logic [63:0]   multiplier_i,
   output logic [127:0]  product_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   logic            r_done;
   logic [127:0]    r_product;
   logic [127:0]    r_mcand;
   logic [65:0]     r_mplier;
   logic [127:0]    r_acc;
   logic [5:0]      r_cnt;

   logic [127:0]    w_mcand_x2;
   logic [127:0]    w_addend;
   logic [127:0]    w_acc_sum;
   logic            w_last;

   assign done_o     = r_done;
   assign product_o  = r_product;
   assign w_mcand_x2 = {r_mcand[126:0], 1'b0};

   // Booth digit d = -2*m[2] + m[1] + m[0] selects the partial product.
   always_comb begin
      w_addend = '0;
      case (r_mplier[2:0])
         3'b001, 3'b010: w_addend = r_mcand;
         3'b011:         w_addend = w_mcand_x2;
         3'b100:         w_addend = ~w_mcand_x2 + 128'd1;
         3'b101, 3'b110: w_addend = ~r_mcand + 128'd1;
         default:        w_addend = '0;
      endcase
   end

   assign w_acc_sum = r_acc + w_addend;

`ifdef MUL_64B_EARLY_EXIT_EN
   // After this step the window starts at m[2]; uniform upper bits mean all later digits are zero.
   logic w_rest_zero;
   assign w_rest_zero = (&r_mplier[65:2]) | ~(|r_mplier[65:2]);
   assign w_last      = (r_cnt == 6'd31) | w_rest_zero;
`else
   assign w_last      = (r_cnt == 6'd31);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_done    <= 1'b1;
         r_product <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (init_i) begin
                  r_mcand  <= {{64{multiplicand_i[63]}}, multiplicand_i};
                  r_mplier <= {multiplier_i[63], multiplier_i, 1'b0};
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_done   <= 1'b0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= {r_mcand[125:0], 2'b00};
               r_mplier <= {{2{r_mplier[65]}}, r_mplier[65:2]};
               r_cnt    <= r_cnt + 6'd1;
               if (w_last) begin
                  r_product <= w_acc_sum;
                  r_done    <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_64b.sv
// Self-checking bench for mul_64b: directed cases plus randomized operands against an arithmetic model.
module tb_mul_64b;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          init_i;
   logic          done_o;
   logic [63:0]   multiplicand_i;
   logic [63:0]   multiplier_i;
   logic [127:0]  product_o;

   bit            clk_run = 1'b0;
   int            n_chk   = 0;
   int            n_pass  = 0;
   int            n_fail  = 0;
   logic [127:0]  last_prod;

   mul_64b dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .init_i         (init_i),
      .done_o         (done_o),
      .multiplicand_i (multiplicand_i),
      .multiplier_i   (multiplier_i),
      .product_o      (product_o)
   );

   always begin
      #5;
      if (clk_run) clk_i = ~clk_i;
   end

   task automatic wait_clk();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_prod(input logic [63:0] x, input logic [63:0] y);
      logic signed [127:0] ex;
      logic signed [127:0] ey;
      ex = $signed(x);
      ey = $signed(y);
      return ex * ey;
   endfunction

   // Busy cycles: smallest n with B[63:2n-1] uniform when early exit is built, else 32.
   function automatic int model_lat(input logic [63:0] y);
`ifdef MUL_64B_EARLY_EXIT_EN
      logic signed [63:0] r;
      for (int n = 1; n <= 32; n++) begin
         r = $signed(y) >>> (2 * n - 1);
         if (r == 64'sd0 || r == -64'sd1) return n;
      end
      return 32;
`else
      return (y === 64'hx) ? 0 : 32;
`endif
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic run_op(input logic [63:0] x, input logic [63:0] y, input string tag);
      int          lat;
      int          exp_lat;
      logic [127:0] exp_p;
      exp_p          = model_prod(x, y);
      exp_lat        = model_lat(y);
      multiplicand_i = x;
      multiplier_i   = y;
      init_i         = 1'b1;
      wait_clk();
      init_i         = 1'b0;
      multiplicand_i = rand64();
      multiplier_i   = rand64();
      chk({tag, " busy"}, 128'(done_o), 128'd0);
      chk({tag, " hold"}, product_o, last_prod);
      lat = 0;
      while (!done_o && lat < 40) begin
         wait_clk();
         lat++;
      end
      chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, " product"}, product_o, exp_p);
      last_prod = exp_p;
   endtask

   initial begin
      int c;
      int inject;
      int exp_lat;
      int sh;
      logic [63:0] x;
      logic [63:0] y;
      logic signed [63:0] t;

      rst_i          = 1'b1;
      init_i         = 1'b0;
      multiplicand_i = '0;
      multiplier_i   = '0;
      last_prod      = '0;
      #1;
      chk("reset done", 128'(done_o), 128'd1);
      chk("reset product", product_o, 128'd0);
      rst_i = 1'b0;
      #1;
      clk_run = 1'b1;
      wait_clk();

      run_op(64'd3, -64'sd5, "3x-5");
      chk("3x-5 const", product_o, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "minxmin");
      chk("minxmin const", product_o, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, -64'sd1, "maxx-1");
      chk("maxx-1 const", product_o, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001);

      // Reset with the clock stopped must act immediately.
      clk_run = 1'b0;
      #20;
      rst_i = 1'b1;
      #1;
      chk("async rst done", 128'(done_o), 128'd1);
      chk("async rst product", product_o, 128'd0);
      rst_i = 1'b0;
      #1;
      clk_run   = 1'b1;
      last_prod = '0;
      wait_clk();

      // init_i raised mid-operation is ignored, then held high it restarts right after completion.
      multiplicand_i = 64'd7;
      multiplier_i   = 64'd6;
      init_i         = 1'b1;
      wait_clk();
      init_i  = 1'b0;
      exp_lat = model_lat(64'd6);
      inject  = (exp_lat > 5) ? 5 : 1;
      c = 0;
      while (!done_o && c < 40) begin
         wait_clk();
         c++;
         if (c == inject && !done_o) begin
            init_i         = 1'b1;
            multiplicand_i = 64'd9;
            multiplier_i   = 64'd9;
         end
      end
      chk("busy-init latency", 128'(c), 128'(exp_lat));
      chk("busy-init product", product_o, 128'd42);
      wait_clk();
      init_i = 1'b0;
      chk("restart busy", 128'(done_o), 128'd0);
      chk("restart hold", product_o, 128'd42);
      c = 0;
      while (!done_o && c < 40) begin
         wait_clk();
         c++;
      end
      chk("restart latency", 128'(c), 128'(model_lat(64'd9)));
      chk("restart product", product_o, 128'd81);
      last_prod = 128'd81;

      // Reset in the middle of an operation.
      multiplicand_i = rand64();
      multiplier_i   = 64'h4000_0000_0000_0000;
      init_i         = 1'b1;
      wait_clk();
      init_i = 1'b0;
      repeat (10) wait_clk();
      chk("midop busy", 128'(done_o), 128'd0);
      rst_i = 1'b1;
      #1;
      chk("midop rst done", 128'(done_o), 128'd1);
      chk("midop rst product", product_o, 128'd0);
      rst_i     = 1'b0;
      last_prod = '0;
      run_op(-64'sd2, -64'sd3, "post-reset");
      chk("post-reset const", product_o, 128'd6);

      run_op(64'd5, 64'd2, "5x2");
      run_op(64'd5, -64'sd1, "5x-1");
      run_op(64'd2, 64'h4000_0000_0000_0000, "2x2^62");
      chk("2x2^62 const", product_o, 128'h0000_0000_0000_0000_8000_0000_0000_0000);
      run_op(64'd0, 64'd0, "0x0");

      for (int i = 0; i < 300; i++) begin
         x = rand64();
         case ($urandom_range(0, 3))
            0: y = rand64();
            1: begin
               t  = rand64();
               sh = $urandom_range(0, 63);
               y  = t >>> sh;
            end
            2: begin
               case ($urandom_range(0, 4))
                  0: y = 64'd0;
                  1: y = 64'd1;
                  2: y = 64'hFFFF_FFFF_FFFF_FFFF;
                  3: y = 64'h8000_0000_0000_0000;
                  default: y = 64'h7FFF_FFFF_FFFF_FFFF;
               endcase
            end
            default: begin
               y = rand64();
               x = ($urandom_range(0, 1) == 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            end
         endcase
         run_op(x, y, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
